// File: rtl/anti_theft_if.sv
// Signal bundle between the anti-theft controller and its environment.
// FUEL_PUMP_EN adds the immobiliser inputs and the fuel pump output.
interface anti_theft_if;
    logic       ignition;
    logic       driver_door;
    logic       passenger_door;
    logic       reprogram;
    logic [1:0] prog_sel;
    logic [3:0] prog_value;
    logic       expired;
    logic       two_hz_enable;
    logic [3:0] value;
    logic       start_timer;
    logic       status_led;
    logic       siren;
`ifdef FUEL_PUMP_EN
    logic       hidden_switch;
    logic       brake_pedal;
    logic       fuel_pump;
`endif

`ifdef FUEL_PUMP_EN
    modport master (
        input  ignition, driver_door, passenger_door, reprogram, prog_sel, prog_value,
               expired, two_hz_enable, hidden_switch, brake_pedal,
        output value, start_timer, status_led, siren, fuel_pump
    );
    modport slave (
        output ignition, driver_door, passenger_door, reprogram, prog_sel, prog_value,
               expired, two_hz_enable, hidden_switch, brake_pedal,
        input  value, start_timer, status_led, siren, fuel_pump
    );
`else
    modport master (
        input  ignition, driver_door, passenger_door, reprogram, prog_sel, prog_value,
               expired, two_hz_enable,
        output value, start_timer, status_led, siren
    );
    modport slave (
        output ignition, driver_door, passenger_door, reprogram, prog_sel, prog_value,
               expired, two_hz_enable,
        input  value, start_timer, status_led, siren
    );
`endif
endinterface

// File: rtl/anti_theft_fsm.sv
// Anti-theft control FSM: owns the interval table and drives the countdown timer handshake.
// Optional FUEL_PUMP_EN adds the hidden-switch/brake fuel pump immobiliser.
//
//  state       | meaning
//  ARMED       | armed, LED blinks at 1 Hz
//  TRIGGERED   | door opened while armed, grace countdown
//  ALARM       | siren on, waiting for all doors closed
//  ALARM_HOLD  | siren held for the alarm interval
//  DISARMED    | ignition on
//  WAIT_OPEN   | ignition off, waiting for driver door to open
//  WAIT_CLOSE  | waiting for driver door to close
//  ARM_DELAY   | arm delay countdown
module anti_theft_fsm #(
    parameter int T_ARM_DEFAULT       = 6,
    parameter int T_DRIVER_DEFAULT    = 8,
    parameter int T_PASSENGER_DEFAULT = 15,
    parameter int T_ALARM_DEFAULT     = 10
) (
    input  logic          clock,
    input  logic          reset,
    anti_theft_if.master  bus
);

    typedef enum logic [2:0] {
        ST_ARMED,
        ST_TRIGGERED,
        ST_ALARM,
        ST_ALARM_HOLD,
        ST_DISARMED,
        ST_WAIT_OPEN,
        ST_WAIT_CLOSE,
        ST_ARM_DELAY
    } state_t;

    localparam logic [1:0] SEL_ARM       = 2'd0;
    localparam logic [1:0] SEL_DRIVER    = 2'd1;
    localparam logic [1:0] SEL_PASSENGER = 2'd2;
    localparam logic [1:0] SEL_ALARM     = 2'd3;

    state_t     state;
    logic [3:0] tbl [4];
    logic [3:0] value_q;
    logic       start_q;
    logic       led_q;
    logic       siren_q;
    logic       any_door;
    logic       expiry;

    assign any_door = bus.driver_door | bus.passenger_door;
    // Only a running countdown may end a timed state; stale pulses are dropped.
    assign expiry   = bus.expired & start_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_ARMED;
            tbl[0]  <= 4'(T_ARM_DEFAULT);
            tbl[1]  <= 4'(T_DRIVER_DEFAULT);
            tbl[2]  <= 4'(T_PASSENGER_DEFAULT);
            tbl[3]  <= 4'(T_ALARM_DEFAULT);
            value_q <= 4'd0;
            start_q <= 1'b0;
            led_q   <= 1'b0;
            siren_q <= 1'b0;
        end else if (bus.reprogram) begin
            tbl[bus.prog_sel] <= bus.prog_value;
            state   <= ST_ARMED;
            start_q <= 1'b0;
            led_q   <= 1'b0;
            siren_q <= 1'b0;
        end else if (bus.ignition && state != ST_DISARMED) begin
            state   <= ST_DISARMED;
            start_q <= 1'b0;
            led_q   <= 1'b0;
            siren_q <= 1'b0;
        end else begin
            case (state)
                ST_ARMED: begin
                    siren_q <= 1'b0;
                    if (bus.driver_door) begin
                        state   <= ST_TRIGGERED;
                        value_q <= tbl[SEL_DRIVER];
                        start_q <= 1'b0;
                        led_q   <= 1'b1;
                    end else if (bus.passenger_door) begin
                        state   <= ST_TRIGGERED;
                        value_q <= tbl[SEL_PASSENGER];
                        start_q <= 1'b0;
                        led_q   <= 1'b1;
                    end else if (bus.two_hz_enable) begin
                        led_q   <= ~led_q;
                    end
                end
                ST_TRIGGERED: begin
                    led_q <= 1'b1;
                    if (expiry) begin
                        state   <= ST_ALARM;
                        start_q <= 1'b0;
                        siren_q <= 1'b1;
                    end else begin
                        start_q <= 1'b1;
                    end
                end
                ST_ALARM: begin
                    led_q   <= 1'b1;
                    siren_q <= 1'b1;
                    start_q <= 1'b0;
                    if (!any_door) begin
                        state   <= ST_ALARM_HOLD;
                        value_q <= tbl[SEL_ALARM];
                    end
                end
                ST_ALARM_HOLD: begin
                    if (any_door) begin
                        state   <= ST_ALARM;
                        start_q <= 1'b0;
                    end else if (expiry) begin
                        state   <= ST_ARMED;
                        start_q <= 1'b0;
                        led_q   <= 1'b0;
                        siren_q <= 1'b0;
                    end else begin
                        start_q <= 1'b1;
                    end
                end
                ST_DISARMED: begin
                    led_q   <= 1'b0;
                    siren_q <= 1'b0;
                    start_q <= 1'b0;
                    if (!bus.ignition) state <= ST_WAIT_OPEN;
                end
                ST_WAIT_OPEN: begin
                    start_q <= 1'b0;
                    if (bus.driver_door) state <= ST_WAIT_CLOSE;
                end
                ST_WAIT_CLOSE: begin
                    start_q <= 1'b0;
                    if (!bus.driver_door) begin
                        state   <= ST_ARM_DELAY;
                        value_q <= tbl[SEL_ARM];
                    end
                end
                ST_ARM_DELAY: begin
                    led_q <= 1'b0;
                    if (any_door) begin
                        state   <= ST_WAIT_CLOSE;
                        start_q <= 1'b0;
                    end else if (expiry) begin
                        state   <= ST_ARMED;
                        start_q <= 1'b0;
                    end else begin
                        start_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_ARMED;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.value       = value_q;
    assign bus.start_timer = start_q;
    assign bus.status_led  = led_q;
    assign bus.siren       = siren_q;

`ifdef FUEL_PUMP_EN
    logic pump_q;

    // Immobiliser latch: independent of the alarm state machine.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pump_q <= 1'b0;
        end else if (bus.ignition && bus.hidden_switch && bus.brake_pedal) begin
            pump_q <= 1'b1;
        end else if (!bus.ignition) begin
            pump_q <= 1'b0;
        end
    end

    assign bus.fuel_pump = pump_q;
`endif

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Directed bench for anti_theft_fsm; the timer is emulated by driving expired by hand.
// Build with FUEL_PUMP_EN defined to also exercise the fuel pump latch.
module tb_anti_theft_fsm;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    anti_theft_if bus ();

    anti_theft_fsm dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset                = 1'b0;
        bus.ignition         = 1'b0;
        bus.driver_door      = 1'b0;
        bus.passenger_door   = 1'b0;
        bus.reprogram        = 1'b0;
        bus.prog_sel         = 2'd0;
        bus.prog_value       = 4'd0;
        bus.expired          = 1'b0;
        bus.two_hz_enable    = 1'b0;
`ifdef FUEL_PUMP_EN
        bus.hidden_switch    = 1'b0;
        bus.brake_pedal      = 1'b0;
`endif

        // reset
        step();
        step();
        reset = 1'b1;
        check4("rst_value", bus.value, 4'd0);
        check1("rst_start", bus.start_timer, 1'b0);
        check1("rst_led", bus.status_led, 1'b0);
        check1("rst_siren", bus.siren, 1'b0);
`ifdef FUEL_PUMP_EN
        check1("rst_pump", bus.fuel_pump, 1'b0);
`endif

        // ARMED blink
        bus.two_hz_enable = 1'b1; step(); bus.two_hz_enable = 1'b0;
        check1("blink_1", bus.status_led, 1'b1);
        step();
        check1("blink_hold", bus.status_led, 1'b1);
        bus.two_hz_enable = 1'b1; step(); bus.two_hz_enable = 1'b0;
        check1("blink_2", bus.status_led, 1'b0);

        // driver door trigger
        bus.driver_door = 1'b1; step();
        check4("trig_drv_value", bus.value, 4'd8);
        check1("trig_drv_start0", bus.start_timer, 1'b0);
        check1("trig_drv_led", bus.status_led, 1'b1);
        bus.driver_door = 1'b0; step();
        check1("trig_drv_start1", bus.start_timer, 1'b1);
        step(); step(); step();
        check1("trig_no_siren", bus.siren, 1'b0);
        check1("trig_still_run", bus.start_timer, 1'b1);
        bus.expired = 1'b1; step(); bus.expired = 1'b0;
        check1("alarm_siren", bus.siren, 1'b1);
        check1("alarm_start", bus.start_timer, 1'b0);
        check1("alarm_led", bus.status_led, 1'b1);

        // doors already closed: ALARM -> ALARM_HOLD
        step();
        check4("hold_value", bus.value, 4'd10);
        check1("hold_start0", bus.start_timer, 1'b0);
        check1("hold_siren", bus.siren, 1'b1);
        bus.expired = 1'b1; step(); bus.expired = 1'b0;
        check1("hold_stale_start", bus.start_timer, 1'b1);
        check1("hold_stale_siren", bus.siren, 1'b1);
        bus.passenger_door = 1'b1; step();
        check1("realarm_start", bus.start_timer, 1'b0);
        check1("realarm_siren", bus.siren, 1'b1);
        bus.passenger_door = 1'b0; step();
        check1("rehold_start0", bus.start_timer, 1'b0);
        step();
        check1("rehold_start1", bus.start_timer, 1'b1);
        bus.expired = 1'b1; step(); bus.expired = 1'b0;
        check1("rearm_siren", bus.siren, 1'b0);
        check1("rearm_start", bus.start_timer, 1'b0);
        check1("rearm_led", bus.status_led, 1'b0);

        // reprogram passenger interval, then passenger trigger
        bus.reprogram = 1'b1; bus.prog_sel = 2'd2; bus.prog_value = 4'd3;
        step();
        bus.reprogram = 1'b0;
        check1("reprog_start", bus.start_timer, 1'b0);
        bus.passenger_door = 1'b1; step();
        check4("trig_pass_value", bus.value, 4'd3);
        check1("trig_pass_start0", bus.start_timer, 1'b0);
        step();
        check1("trig_pass_start1", bus.start_timer, 1'b1);
        bus.passenger_door = 1'b0;
        bus.ignition = 1'b1; step();
        check1("disarm_start", bus.start_timer, 1'b0);
        check1("disarm_led", bus.status_led, 1'b0);
        check1("disarm_siren", bus.siren, 1'b0);
        step();

        // disarm / arm-delay sequence
        bus.ignition = 1'b0; step();
        bus.driver_door = 1'b1; step();
        bus.driver_door = 1'b0; step();
        check4("armdly_value", bus.value, 4'd6);
        check1("armdly_start0", bus.start_timer, 1'b0);
        step();
        check1("armdly_start1", bus.start_timer, 1'b1);
        step(); step(); step();
        bus.driver_door = 1'b1; step();
        check1("armdly_reopen", bus.start_timer, 1'b0);
        bus.driver_door = 1'b0; step();
        check1("armdly_gap", bus.start_timer, 1'b0);
        check4("armdly_value2", bus.value, 4'd6);
        step();
        check1("armdly_restart", bus.start_timer, 1'b1);
        check1("armdly_led", bus.status_led, 1'b0);
        bus.expired = 1'b1; step(); bus.expired = 1'b0;
        check1("armed_start", bus.start_timer, 1'b0);
        bus.two_hz_enable = 1'b1; step(); bus.two_hz_enable = 1'b0;
        check1("armed_blink", bus.status_led, 1'b1);

        // both doors together pick the driver interval
        bus.driver_door = 1'b1; bus.passenger_door = 1'b1; step();
        check4("both_value", bus.value, 4'd8);
        step();
        check1("both_start1", bus.start_timer, 1'b1);
        bus.reprogram = 1'b1; bus.prog_sel = 2'd1; bus.prog_value = 4'd5;
        step();
        bus.reprogram = 1'b0;
        check1("reprog_mid_start", bus.start_timer, 1'b0);
        check4("reprog_mid_value", bus.value, 4'd8);
        step();
        check4("new_drv_value", bus.value, 4'd5);
        check1("new_drv_start0", bus.start_timer, 1'b0);
        step();
        check1("new_drv_start1", bus.start_timer, 1'b1);

        // reset mid-countdown
        reset = 1'b0; step();
        check4("midrst_value", bus.value, 4'd0);
        check1("midrst_start", bus.start_timer, 1'b0);
        check1("midrst_led", bus.status_led, 1'b0);
        reset = 1'b1;
        bus.driver_door = 1'b0; bus.passenger_door = 1'b0;
        step();
        check1("post_rst_start", bus.start_timer, 1'b0);

`ifdef FUEL_PUMP_EN
        bus.ignition = 1'b1; bus.hidden_switch = 1'b1; step();
        check1("pump_no_brake", bus.fuel_pump, 1'b0);
        bus.brake_pedal = 1'b1; step();
        check1("pump_on", bus.fuel_pump, 1'b1);
        bus.hidden_switch = 1'b0; bus.brake_pedal = 1'b0; step();
        check1("pump_hold", bus.fuel_pump, 1'b1);
        bus.ignition = 1'b0; step();
        check1("pump_off", bus.fuel_pump, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
